// File: rtl/maxpool_window_scheduler_if.sv
// Handshake and buffer-port bundle for the max-pooling window scheduler.
// master: scheduler side; slave: control logic and buffer side.
interface maxpool_window_scheduler_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 10
);
   logic              start;
   logic              busy;
   logic              done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      input  start, rd_data,
      output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, rd_data,
      input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/maxpool_window_scheduler.sv
// 2x2 stride-2 max-pool sequencer: four reads per window, one pooled write, paced every DIV clocks.
// Optional MAXPOOL_RELU_EN clamps negative pooled results to zero on write.
module maxpool_window_scheduler #(
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DIV    = 6
) (
   input  logic                        clock_in,
   input  logic                        reset,
   maxpool_window_scheduler_if.master  bus
);
   localparam int unsigned OUT_W = IMG_W / 2;
   localparam int unsigned OUT_H = IMG_H / 2;
   localparam int unsigned CNT_W = $clog2(DIV);
   localparam int unsigned OX_W  = $clog2(OUT_W + 1);
   localparam int unsigned OY_W  = $clog2(OUT_H + 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [OX_W-1:0]           ox_q, ox_d;
   logic [OY_W-1:0]           oy_q, oy_d;
   logic [1:0]                k_q, k_d;
   logic signed [DATA_W-1:0]  max_q, max_d;
   logic                      rd_pend_q, rd_pend_d;
   logic                      rd_first_q, rd_first_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
   logic                      wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]         wr_data_q, wr_data_d;

   logic                      step_c;
   logic                      last_win_c;
   logic signed [DATA_W-1:0]  rd_sdata_c;
   logic signed [DATA_W-1:0]  wr_val_c;

   assign step_c     = (cnt_q == CNT_W'(DIV - 1));
   assign last_win_c = (ox_q == OX_W'(OUT_W - 1)) && (oy_q == OY_W'(OUT_H - 1));
   assign rd_sdata_c = bus.rd_data;

   // Running max; the read data lands the cycle after rd_en, so max_d already folds it in.
   always_comb begin
      max_d = max_q;
      if (rd_pend_q) begin
         if (rd_first_q || (rd_sdata_c > max_q)) begin
            max_d = rd_sdata_c;
         end
      end
   end

`ifdef MAXPOOL_RELU_EN
   assign wr_val_c = max_d[DATA_W-1] ? '0 : max_d;
`else
   assign wr_val_c = max_d;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ox_d       = ox_q;
      oy_d       = oy_q;
      k_d        = k_q;
      rd_pend_d  = rd_en_q;
      rd_first_d = rd_first_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      if (state_q != S_IDLE) begin
         cnt_d = step_c ? '0 : cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_READ;
               cnt_d   = '0;
               ox_d    = '0;
               oy_d    = '0;
               k_d     = '0;
               busy_d  = 1'b1;
            end
         end
         S_READ: begin
            if (step_c) begin
               rd_en_d    = 1'b1;
               rd_addr_d  = ADDR_W'((32'(oy_q) * 2 + 32'(k_q[1])) * IMG_W
                                    + 32'(ox_q) * 2 + 32'(k_q[0]));
               rd_first_d = (k_q == 2'd0);
               k_d        = k_q + 2'd1;
               if (k_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // wr_en_q can only be high here after the final window's write.
            if (wr_en_q) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (step_c) begin
               wr_en_d   = 1'b1;
               wr_addr_d = ADDR_W'(32'(oy_q) * OUT_W + 32'(ox_q));
               wr_data_d = wr_val_c;
               if (!last_win_c) begin
                  state_d = S_READ;
                  k_d     = '0;
                  if (ox_q == OX_W'(OUT_W - 1)) begin
                     ox_d = '0;
                     oy_d = oy_q + OY_W'(1);
                  end else begin
                     ox_d = ox_q + OX_W'(1);
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         k_q        <= '0;
         max_q      <= '0;
         rd_pend_q  <= 1'b0;
         rd_first_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         k_q        <= k_d;
         max_q      <= max_d;
         rd_pend_q  <= rd_pend_d;
         rd_first_q <= rd_first_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_maxpool_window_scheduler.sv
// Bench for maxpool_window_scheduler: a 4x4/DIV=2 and a 5x5/DIV=3 instance against a window-max model.
module tb_maxpool_window_scheduler;
   logic       clk;
   logic       reset;
   logic       start_r;
   logic       sel;
   int         cyc;
   int         checks;
   int         errors;
   int         overlap;
   logic [7:0] img [25];

   int rd_a_q[$], rd_t_q[$], wr_a_q[$], wr_d_q[$], wr_t_q[$], dn_q[$];

   maxpool_window_scheduler_if #(.DATA_W(8), .ADDR_W(10)) ia ();
   maxpool_window_scheduler_if #(.DATA_W(8), .ADDR_W(10)) ib ();

   maxpool_window_scheduler #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .ADDR_W(10), .DIV(2)) dut_a (
      .clock_in (clk),
      .reset    (reset),
      .bus      (ia)
   );

   maxpool_window_scheduler #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .ADDR_W(10), .DIV(3)) dut_b (
      .clock_in (clk),
      .reset    (reset),
      .bus      (ib)
   );

   assign ia.start = start_r & ~sel;
   assign ib.start = start_r & sel;

   logic       m_busy, m_done, m_rd_en, m_wr_en;
   logic [9:0] m_rd_addr, m_wr_addr;
   logic [7:0] m_wr_data;
   assign m_busy    = sel ? ib.busy    : ia.busy;
   assign m_done    = sel ? ib.done    : ia.done;
   assign m_rd_en   = sel ? ib.rd_en   : ia.rd_en;
   assign m_rd_addr = sel ? ib.rd_addr : ia.rd_addr;
   assign m_wr_en   = sel ? ib.wr_en   : ia.wr_en;
   assign m_wr_addr = sel ? ib.wr_addr : ia.wr_addr;
   assign m_wr_data = sel ? ib.wr_data : ia.wr_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Input buffers: registered read, one clock latency.
   always @(posedge clk) begin
      if (ia.rd_en) ia.rd_data <= (ia.rd_addr < 10'd25) ? img[ia.rd_addr[4:0]] : 8'h00;
      if (ib.rd_en) ib.rd_data <= (ib.rd_addr < 10'd25) ? img[ib.rd_addr[4:0]] : 8'h00;
   end

   initial overlap = 0;
   always @(posedge clk) begin
      #1;
      if (m_rd_en) begin rd_a_q.push_back(int'(m_rd_addr)); rd_t_q.push_back(cyc); end
      if (m_wr_en) begin
         wr_a_q.push_back(int'(m_wr_addr));
         wr_d_q.push_back(int'(m_wr_data));
         wr_t_q.push_back(cyc);
      end
      if (m_done) dn_q.push_back(cyc);
      if (m_rd_en && m_wr_en) overlap = overlap + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},    32'(m_busy),    0);
      check({tag, "_done"},    32'(m_done),    0);
      check({tag, "_rd_en"},   32'(m_rd_en),   0);
      check({tag, "_wr_en"},   32'(m_wr_en),   0);
      check({tag, "_rd_addr"}, 32'(m_rd_addr), 0);
      check({tag, "_wr_addr"}, 32'(m_wr_addr), 0);
      check({tag, "_wr_data"}, 32'(m_wr_data), 0);
   endtask

   // Full pooling pass on the selected instance, checked against the window-max model.
   task automatic run_pool(input string tag, input logic ds, input bit extra);
      int w, h, dv, n, s, budget, best, a, v, rb, wb, db, ov0;
      int e_rd[$], e_wa[$], e_wd[$];
      sel = ds;
      w   = ds ? 5 : 4;
      h   = w;
      dv  = ds ? 3 : 2;
      n   = (w / 2) * (h / 2);
      for (int oy = 0; oy < h / 2; oy++) begin
         for (int ox = 0; ox < w / 2; ox++) begin
            best = -1000;
            for (int k = 0; k < 4; k++) begin
               a = (2 * oy + k / 2) * w + 2 * ox + k % 2;
               e_rd.push_back(a);
               v = int'($signed(img[a]));
               if (v > best) best = v;
            end
`ifdef MAXPOOL_RELU_EN
            if (best < 0) best = 0;
`endif
            e_wa.push_back(oy * (w / 2) + ox);
            e_wd.push_back(best & 255);
         end
      end
      @(negedge clk);
      rb = rd_a_q.size(); wb = wr_a_q.size(); db = dn_q.size(); ov0 = overlap;
      start_r = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      start_r = 1'b0;
      budget = 5 * n * dv + 10;
      while (dn_q.size() == db && budget > 0) begin
         @(negedge clk);
         budget--;
         start_r = extra && (cyc == s + 3);
      end
      if (extra) start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      repeat (2 * dv + 4) @(negedge clk);

      check({tag, "_done_count"}, dn_q.size() - db, 1);
      if (dn_q.size() > db) check({tag, "_done_time"}, dn_q[db] - s, 5 * n * dv + 1);
      check({tag, "_rd_count"}, rd_a_q.size() - rb, 4 * n);
      for (int i = 0; i < 4 * n && rb + i < rd_a_q.size(); i++) begin
         check($sformatf("%s_rd_addr[%0d]", tag, i), rd_a_q[rb + i], e_rd[i]);
         check($sformatf("%s_rd_time[%0d]", tag, i), rd_t_q[rb + i] - s,
               (5 * (i / 4) + i % 4 + 1) * dv);
      end
      check({tag, "_wr_count"}, wr_a_q.size() - wb, n);
      for (int i = 0; i < n && wb + i < wr_a_q.size(); i++) begin
         check($sformatf("%s_wr_addr[%0d]", tag, i), wr_a_q[wb + i], e_wa[i]);
         check($sformatf("%s_wr_data[%0d]", tag, i), wr_d_q[wb + i], e_wd[i]);
         check($sformatf("%s_wr_time[%0d]", tag, i), wr_t_q[wb + i] - s, (5 * i + 5) * dv);
      end
      check({tag, "_overlap"}, overlap - ov0, 0);
      check({tag, "_busy_end"}, 32'(m_busy), 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 25; i++) img[i] = 8'($urandom);
   endtask

   initial begin
      int rb, wb, db, budget, wb0;
      checks  = 0;
      errors  = 0;
      reset   = 1'b1;
      start_r = 1'b0;
      sel     = 1'b0;
      for (int i = 0; i < 25; i++) img[i] = 8'(i);
      repeat (3) @(negedge clk);
      check_zero("rst_a");
      sel = 1'b1;
      check_zero("rst_b");
      sel = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Ramp map: pixel(r,c) = 4r+c.
      run_pool("ramp", 1'b0, 1'b0);

      // Signed compare in window 0.
      fill_random();
      img[0] = 8'hFD; img[1] = 8'hF9; img[4] = 8'hFF; img[5] = 8'h80;
      wb0 = wr_d_q.size();
      run_pool("signed", 1'b0, 1'b0);
`ifdef MAXPOOL_RELU_EN
      check("signed_w0_direct", (wr_d_q.size() > wb0) ? wr_d_q[wb0] : -1, 0);
`else
      check("signed_w0_direct", (wr_d_q.size() > wb0) ? wr_d_q[wb0] : -1, 255);
`endif

      // Ties everywhere.
      for (int i = 0; i < 25; i++) img[i] = 8'h7F;
      run_pool("ties", 1'b0, 1'b0);

      for (int r = 0; r < 3; r++) begin
         fill_random();
         run_pool($sformatf("rand_a%0d", r), 1'b0, 1'b0);
      end
      for (int r = 0; r < 3; r++) begin
         fill_random();
         run_pool($sformatf("odd_b%0d", r), 1'b1, 1'b0);
      end

      // Reset while the second window is at k=2.
      fill_random();
      sel = 1'b0;
      rb = rd_a_q.size();
      @(negedge clk);
      start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      budget = 100;
      while (rd_a_q.size() - rb < 6 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("midrst_reach", rd_a_q.size() - rb, 6);
      reset = 1'b1;
      @(negedge clk);
      check_zero("midrst");
      reset = 1'b0;
      rb = rd_a_q.size(); wb = wr_a_q.size(); db = dn_q.size();
      repeat (30) @(negedge clk);
      check("midrst_no_rd", rd_a_q.size() - rb, 0);
      check("midrst_no_wr", wr_a_q.size() - wb, 0);
      check("midrst_no_done", dn_q.size() - db, 0);
      run_pool("after_rst", 1'b0, 1'b0);

      // Extra starts while busy and during the done cycle.
      for (int i = 0; i < 25; i++) img[i] = 8'(i);
      run_pool("ign_start_a", 1'b0, 1'b1);
      fill_random();
      run_pool("ign_start_b", 1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/maxpool_window_scheduler.md
Name: maxpool_window_scheduler

Overview:
- Sequences the max-pooling stage: walks a stored feature map in 2x2, stride-2 windows, issues four reads per window, keeps a running signed max, and writes one pooled result per window.
- Pacing comes from an internal enable tick every DIV clocks on the single system clock. No derived clock is used.
- Sits between the convolution output buffer (read side) and the pooled-map buffer (write side). Started by the SoC control logic.

Parameters:
- IMG_W, 28, input map width in pixels (min 2)
- IMG_H, 28, input map height in pixels (min 2)
- DATA_W, 8, pixel width, signed two's complement
- ADDR_W, 10, read/write address width; must hold IMG_W*IMG_H-1
- DIV, 6, clocks per scheduler step (min 2)

Ports:
- clock_in  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to pool the whole map
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final write
- rd_en  out  1  one-cycle read strobe to the input buffer
- rd_addr  out  ADDR_W  input buffer address
- rd_data  in  DATA_W  read data, valid exactly 1 clock after rd_en
- wr_en  out  1  one-cycle write strobe to the output buffer
- wr_addr  out  ADDR_W  output buffer address
- wr_data  out  DATA_W  pooled max value

Behaviour:
- Reset: synchronous, active-high. All outputs are 0, FSM goes to IDLE, and all counters clear. Reset in the middle of an operation aborts it with no further strobes and no done pulse.
- Tick counter:
  - cnt counts 0..DIV-1 and wraps; it runs only while busy and is cleared to 0 when start is accepted.
  - step = (cnt == DIV-1). The FSM advances only on step cycles.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE: start=1 is accepted. Clear cnt, ox, oy and k, and move to READ. busy=1 from the next cycle.
  - READ (k = 0..3): on step, pulse rd_en with rd_addr = (2*oy + k[1])*IMG_W + 2*ox + k[0]. The order is (0,0), (0,1), (1,0), (1,1).
    - The cycle after rd_en, capture rd_data: k=0 loads max; k>0 sets max = (rd_data > max) ? rd_data : max, using a signed compare. Ties keep the current value.
    - After k=3 is issued, move to WRITE.
  - WRITE: on step, pulse wr_en with wr_addr = oy*(IMG_W/2) + ox and wr_data = max (the k=3 value is already folded in, since DIV ≥ 2).
    - Then advance: ox+1; on ox = IMG_W/2-1, ox wraps to 0 and oy+1.
    - If the window just written was the last one (ox = IMG_W/2-1 and oy = IMG_H/2-1), go to DONE; otherwise go to READ with k=0.
  - DONE: a single cycle entered on the clock edge after the final wr_en. done=1 and busy=0 are driven in that same cycle, then the FSM returns to IDLE.
- Latency:
  - First rd_en occurs DIV cycles after the edge that samples start. One action follows every DIV cycles.
  - N = (IMG_W/2)*(IMG_H/2) windows. The last wr_en occurs 5*N*DIV cycles after start; done follows 1 cycle later.
- Odd IMG_W or IMG_H: use floor division; the last column or row is skipped.
- start while busy or in DONE is ignored. start on the same cycle as reset: reset wins.
- rd_en and wr_en are never high in the same cycle. rd_addr and wr_addr hold their last value between strobes.

Optional Feature:
- Macro MAXPOOL_RELU_EN.
- Defined: wr_data = (max < 0) ? 0 : max, which fuses ReLU into the pooling write.
- Undefined: wr_data = max unchanged, so negative results pass through.
- Timing and addressing are identical in both builds.

Test Plan:
- Reset behaviour: IMG_W=IMG_H=4, DIV=2, buffer filled with pixel(r,c) = 4r+c, pulse start → rd_addr sequence 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15; wr_addr 0..3; wr_data 5,7,13,15; last wr_en 40 cycles after start; done at 41.
- Signed compare: window values -3, -7, -1, -128 → wr_data = -1 (0xFF) without MAXPOOL_RELU_EN; 0 with MAXPOOL_RELU_EN.
- Ties: all four window values 0x7F → wr_data 0x7F; exactly one wr_en per window.
- Odd size: IMG_W=5, IMG_H=5, DIV=3 → 4 writes, column 4 and row 4 never read, done 61 cycles after start.
- Reset mid-operation: assert reset during the second window's READ k=2 → next cycle all outputs 0, no done; a fresh start restarts from rd_addr 0.
- Ignored start: pulse start while busy → address sequence and done timing unchanged from the single-start run.
